// File: rtl/dp_pkg.sv
// Shared types and defaults for the accumulate datapath sequencer.
// Imported by the sequencer top and its index counter.
package dp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        EXEC,
        DONE
    } state_t;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    localparam int DW  = 8;
    localparam int N_A = 8;
    localparam int N_B = 4;

endpackage

// File: rtl/dp_sequencer_if.sv
// Command/status and datapath control bundle of the sequencer.
// master = sequencer side, slave = command source plus datapath.
interface dp_sequencer_if #(
    parameter int N_A = 8
);

    localparam int NW = $clog2(N_A + 1);

    logic          start;
    logic          abort;
    logic          ge;
    logic          clr_a;
    logic          clr_b;
    logic          inc_a;
    logic          inc_b;
    logic          clr_acc;
    logic          ld_acc;
    logic          sel;
    logic          busy;
    logic          done;
    logic [NW-1:0] n_sub;

    modport master (
        input  start, abort, ge,
        output clr_a, clr_b, inc_a, inc_b,
        output clr_acc, ld_acc, sel,
        output busy, done, n_sub
    );

    modport slave (
        output start, abort, ge,
        input  clr_a, clr_b, inc_a, inc_b,
        input  clr_acc, ld_acc, sel,
        input  busy, done, n_sub
    );

endinterface

// File: rtl/dp_step_counter.sv
// Modulo-N element index with clear, increment and terminal flag.
// Clear wins over increment; the count wraps after N-1.
module dp_step_counter #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == W'(N - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dp_sequencer.sv
// Control FSM for the accumulate datapath: clear, then FETCH/EXEC
// per A element, then a one-cycle done pulse.
module dp_sequencer #(
    parameter int N_A = dp_pkg::N_A,
    parameter int N_B = dp_pkg::N_B
) (
    input  logic clk,
    input  logic reset,
    dp_sequencer_if.master bus
);

    import dp_pkg::*;

    localparam int NW = $clog2(N_A + 1);

    // B wraps on its own in the datapath; only the legality matters here.
    if (N_A < 2 || (N_A & (N_A - 1)) != 0 ||
        N_B < 1 || N_B > N_A || (N_B & (N_B - 1)) != 0) begin : g_bad_cfg
        $error("dp_sequencer: illegal N_A/N_B");
    end

    state_t        state_q;
    state_t        state_d;
    logic [NW-1:0] nsub_q;
    logic [NW-1:0] nsub_d;
    logic          idx_clr;
    logic          idx_inc;
    logic          idx_tc;

    dp_step_counter #(
        .N (N_A)
    ) u_idx (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (idx_clr),
        .inc_i (idx_inc),
        .tc_o  (idx_tc)
    );

    assign bus.n_sub = nsub_q;
    assign bus.busy  = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        nsub_d      = nsub_q;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        bus.clr_a   = 1'b0;
        bus.clr_b   = 1'b0;
        bus.inc_a   = 1'b0;
        bus.inc_b   = 1'b0;
        bus.clr_acc = 1'b0;
        bus.ld_acc  = 1'b0;
        bus.sel     = SEL_ADD;
        bus.done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    bus.clr_a   = 1'b1;
                    bus.clr_b   = 1'b1;
                    bus.clr_acc = 1'b1;
                    nsub_d      = '0;
                    idx_clr     = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                state_d = bus.abort ? IDLE : EXEC;
            end
            EXEC: begin
                bus.sel = bus.ge ? SEL_SUB : SEL_ADD;
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    bus.ld_acc = 1'b1;
                    bus.inc_a  = 1'b1;
                    bus.inc_b  = 1'b1;
                    idx_inc    = 1'b1;
                    if (bus.ge) begin
                        nsub_d = nsub_q + 1'b1;
                    end
                    state_d = idx_tc ? DONE : FETCH;
                end
            end
            DONE: begin
                bus.done = !bus.abort;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            nsub_q  <= '0;
        end else begin
            state_q <= state_d;
            nsub_q  <= nsub_d;
        end
    end

endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Moore/Mealy control FSM that sequences the 8-bit accumulate datapath: address counters A (N_A entries) and B (N_B entries), the add/sub unit with its 2:1 select mux, the comparator and the accumulator D-register. On a `start` pulse it clears the datapath, walks every A index once while B wraps modulo N_B, selects add or subtract per element from the comparator result, and loads the accumulator. Completion is signalled with a one-cycle `done` pulse. It sits between the top-level command interface and the datapath, and is the only driver of datapath control lines.

## Interface
- `N_A`, 8: number of A elements processed per run (≥2, power of 2)
- `N_B`, 4: B wrap length (≥1, power of 2, ≤ N_A)
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; low forces all state and outputs to reset values immediately
- `start`  in  1  run request, sampled only in IDLE
- `abort`  in  1  cancel current run, sampled in every non-IDLE state
- `ge`  in  1  comparator result for current operands: A[i] ≥ B[j]
- `clr_a`, `clr_b`  out  1  synchronous clear of counter A / counter B
- `inc_a`, `inc_b`  out  1  increment enable of counter A / counter B
- `clr_acc`  out  1  load accumulator with 0
- `ld_acc`  out  1  load accumulator with mux output
- `sel`  out  1  mux select: 0 = add, 1 = subtract
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle completion pulse
- `n_sub`  out  $clog2(N_A+1)  number of subtract steps in the last run

## Operation
- States: IDLE, CLEAR, FETCH, EXEC, DONE.
- IDLE: all control outputs 0. `start`=1 and `abort`=0 → CLEAR. Otherwise stay in IDLE.
- CLEAR: `clr_a`=`clr_b`=`clr_acc`=1. `n_sub` ← 0, internal index ← 0. → FETCH.
- FETCH: no outputs asserted. This is the operand-settle cycle for memory read and comparator. → EXEC.
- EXEC: `ld_acc`=1, `sel`=`ge` (combinational, EXEC only), `inc_a`=`inc_b`=1. If `ge`=1, `n_sub` increments. If index = N_A−1 → DONE; else index+1 and → FETCH.
- B index wraps naturally. Element i is paired with B[i mod N_B]. The controller never asserts `clr_b` mid-run.
- DONE: `done`=1 for exactly one cycle. → IDLE. `n_sub` holds until the next CLEAR.
- `abort`=1 in CLEAR/FETCH/EXEC/DONE → IDLE next edge, with no `done` and no `ld_acc` that cycle. `n_sub` freezes at its partial value.
- `start` while busy is ignored, not queued.
- `sel`=0 whenever not in EXEC.

## Timing
- Reset values: state IDLE; all outputs 0; `n_sub`=0.
- `start` high at edge k → CLEAR during cycle k+1. Elements occupy 2 cycles each (FETCH, EXEC). The last EXEC ends at cycle k+2·N_A+1. `done` is high in cycle k+2·N_A+2 (cycle 18 for defaults). `busy` is high in cycles k+1 … k+2·N_A+2.
- The accumulator load and the counter increments share the EXEC edge. The datapath must hold its counters when `inc` is 0.
- `reset` asserted mid-run → IDLE asynchronously. The run is lost; no `done`.
- `abort` has priority over all other transitions. `abort` and `start` together in IDLE → stay in IDLE.
- A back-to-back `start` in the cycle after `done` is accepted (IDLE → CLEAR).

## Structure
- Shared package `dp_pkg`: state enum (IDLE, CLEAR, FETCH, EXEC, DONE), `SEL_ADD`=1'b0, `SEL_SUB`=1'b1, default widths DW=8, N_A=8, N_B=4.
- One natural sub-module, `dp_step_counter`: a parameterised index counter with clear, increment and terminal-count flag, used for the element index.
- Output decode is combinational from state (plus `ge` for `sel`). `n_sub` and the index are registered.

## Test plan
- Reset during EXEC (reset low at cycle 5) → outputs 0 immediately; state IDLE; `n_sub`=0; no `done`.
- `start` pulse with `ge` held 0 → exactly 8 `ld_acc` pulses with `sel`=0; `inc_a` 8 times; `done` at cycle 18; `n_sub`=0.
- `start` with `ge`=1 on elements 1, 4, 6 → `sel`=1 only in those EXEC cycles; `n_sub`=3 after `done`.
- `abort` in the FETCH of element 3 → IDLE next cycle; no `done`; `n_sub` holds partial count; a following `start` runs a full 18-cycle sequence.
- `start` re-asserted during run, then `start` the cycle after `done` → the first is ignored; the second enters CLEAR immediately.
- `start` and `abort` together in IDLE → remains IDLE; `busy`=0.
